// File: rtl/scan_select_gen_pkg.sv
// Shared types for the scan select sequencer: select width, state encoding and
// the {x,y,z} view of the decoder select index.
package scan_pkg;

  localparam int SEL_W   = 3;
  localparam int NUM_OUT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BLANK = 2'd2
  } scan_state_e;

  typedef logic [SEL_W-1:0] sel_idx_t;

  typedef struct packed {
    logic x;
    logic y;
    logic z;
  } sel_t;

endpackage

// File: rtl/scan_select_gen_if.sv
// Control and select bundle between a scan controller (master) and the
// sequencer (slave). start/stop are single-cycle pulses; outputs are registered.
interface scan_select_gen_if;
  import scan_pkg::*;

  logic             start;
  logic             stop;
  logic             cont;
  logic [SEL_W-1:0] last_idx;
  logic             x;
  logic             y;
  logic             z;
  logic             sel_valid;
  logic             busy;
  logic             frame_done;

  modport master (
    output start, stop, cont, last_idx,
    input  x, y, z, sel_valid, busy, frame_done
  );

  modport slave (
    input  start, stop, cont, last_idx,
    output x, y, z, sel_valid, busy, frame_done
  );

endinterface

// File: rtl/scan_select_gen_prescaler.sv
// Slot prescaler: counts 0..DIV-1 while enabled, clear has priority.
// tc flags the current terminal count, tc_next the terminal count one cycle ahead.
module scan_prescaler #(
  parameter  int DIV   = 100,
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc,
  output logic tc_next
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc      = (cnt_q == LAST);
  assign tc_next = (cnt_d == LAST);

endmodule

// File: rtl/scan_select_gen.sv
// Decoder select sequencer: steps {x,y,z} through 0..last_idx, DIV cycles per slot.
// Define SCAN_BLANK_EN to insert one blanked cycle after every advancing slot end.
module scan_select_gen
  import scan_pkg::*;
#(
  parameter int DIV = 100
) (
  input  logic                clk,
  input  logic                rst,
  scan_select_gen_if.slave    bus,
  output scan_state_e         state_dbg_o
);

  scan_state_e state_q, state_d;
  sel_idx_t    idx_q, idx_d;
  sel_idx_t    last_q, last_d;
  logic        cont_q, cont_d;
  logic        stop_pend_q, stop_pend_d;
  logic        sel_valid_q, busy_q, frame_done_q;
  logic        sel_valid_d, busy_d, frame_done_d;
  logic        pre_clr, pre_en, pre_tc, pre_tc_next;
  sel_t        sel;

  scan_prescaler #(.DIV(DIV)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .clr     (pre_clr),
    .en      (pre_en),
    .tc      (pre_tc),
    .tc_next (pre_tc_next)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    cont_d      = cont_q;
    stop_pend_d = stop_pend_q;
    pre_clr     = 1'b0;
    pre_en      = 1'b0;
    case (state_q)
      IDLE: begin
        pre_clr = 1'b1;
        if (bus.start) begin
          state_d     = RUN;
          idx_d       = '0;
          last_d      = bus.last_idx;
          cont_d      = bus.cont;
          stop_pend_d = 1'b0;
        end
      end
      RUN: begin
        pre_en = 1'b1;
        if (bus.stop) stop_pend_d = 1'b1;
        // A stop arriving in the slot's final cycle is held for the next slot.
        if (pre_tc) begin
          if (stop_pend_q || ((idx_q == last_q) && !cont_q)) begin
            state_d     = IDLE;
            idx_d       = '0;
            stop_pend_d = 1'b0;
          end else begin
            idx_d = (idx_q == last_q) ? '0 : idx_q + sel_idx_t'(1);
`ifdef SCAN_BLANK_EN
            state_d = BLANK;
            pre_clr = 1'b1;
`endif
          end
        end
      end
`ifdef SCAN_BLANK_EN
      BLANK: begin
        pre_clr = 1'b1;
        if (bus.stop) stop_pend_d = 1'b1;
        state_d = RUN;
      end
`endif
      default: begin
        state_d     = IDLE;
        idx_d       = '0;
        stop_pend_d = 1'b0;
      end
    endcase
  end

  // Qualifiers are registered from the next state so they line up with idx_q.
  always_comb begin
    sel_valid_d  = (state_d == RUN);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == RUN) && pre_tc_next && (idx_d == last_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      last_q       <= '0;
      cont_q       <= 1'b0;
      stop_pend_q  <= 1'b0;
      sel_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      cont_q       <= cont_d;
      stop_pend_q  <= stop_pend_d;
      sel_valid_q  <= sel_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sel            = sel_t'(idx_q);
  assign bus.x          = sel.x;
  assign bus.y          = sel.y;
  assign bus.z          = sel.z;
  assign bus.sel_valid  = sel_valid_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_scan_select_gen.sv
// Bench for scan_select_gen: four instances (DIV 4,3,2,1) share one stimulus
// stream and are compared every cycle against a slot-arithmetic reference model.
module tb_scan_select_gen;
  import scan_pkg::*;

  localparam int NU = 4;
  localparam int DIVS [NU] = '{4, 3, 2, 1};
`ifdef SCAN_BLANK_EN
  localparam int BL = 1;
`else
  localparam int BL = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       cont = 1'b0;
  logic [2:0] last_idx = 3'd0;

  logic [5:0] obs [NU];   // {idx[2:0], sel_valid, busy, frame_done}
  logic [5:0] exp_v [NU];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int cyc = 0;
  int fd_cnt [NU];
  int busy_cnt [NU];
  int last_seen [NU];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : gen_u
    scan_select_gen_if u_if ();
    scan_state_e st;
    assign u_if.start    = start;
    assign u_if.stop     = stop;
    assign u_if.cont     = cont;
    assign u_if.last_idx = last_idx;
    assign obs[g] = {u_if.x, u_if.y, u_if.z, u_if.sel_valid, u_if.busy, u_if.frame_done};
    scan_select_gen #(.DIV(DIVS[g])) u_dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (u_if.slave),
      .state_dbg_o (st)
    );
  end

  // Reference model: position m_t within the run fixes slot, index and qualifiers.
  bit m_act [NU];
  bit m_cont [NU];
  bit m_stop [NU];
  int m_t [NU];
  int m_l [NU];
  initial begin
    int d, p, w, s, ix;
    bit v, fd;
    for (int u = 0; u < NU; u++) begin
      m_act[u] = 0; m_cont[u] = 0; m_stop[u] = 0; m_t[u] = 0; m_l[u] = 0; exp_v[u] = '0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int u = 0; u < NU; u++) begin
        d = DIVS[u];
        p = d + BL;
        if (rst) begin
          m_act[u] = 0; m_stop[u] = 0;
        end else if (!m_act[u]) begin
          if (start) begin
            m_act[u] = 1; m_t[u] = 0; m_l[u] = int'(last_idx); m_cont[u] = cont; m_stop[u] = 0;
          end
        end else begin
          w = m_t[u] % p;
          s = m_t[u] / p;
          if (w == d - 1) begin
            ix = s % (m_l[u] + 1);
            if (m_stop[u] || (!m_cont[u] && ix == m_l[u])) begin
              m_act[u] = 0; m_stop[u] = 0;
            end else begin
              if (stop) m_stop[u] = 1;
              m_t[u]++;
            end
          end else begin
            if (stop) m_stop[u] = 1;
            m_t[u]++;
          end
        end
        if (!m_act[u]) begin
          exp_v[u] = '0;
        end else begin
          w  = m_t[u] % p;
          s  = m_t[u] / p;
          v  = (w < d);
          ix = v ? (s % (m_l[u] + 1)) : ((s + 1) % (m_l[u] + 1));
          fd = v && (w == d - 1) && (ix == m_l[u]);
          exp_v[u] = {3'(ix), v, 1'b1, fd};
        end
      end
    end
  end

  // Per-cycle compare and observation counters.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int u = 0; u < NU; u++) begin
          checks++;
          if (obs[u] !== exp_v[u]) begin
            errors++;
            $display("FAIL cycle_cmp unit=%0d cycle=%0d got=%b expected=%b", u, cyc, obs[u], exp_v[u]);
          end
          fd_cnt[u]   += int'(obs[u][0]);
          busy_cnt[u] += int'(obs[u][1]);
          if (obs[u][2]) last_seen[u] = int'(obs[u][5:3]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, req);
    end
  endtask

  task automatic clear_cnt();
    for (int u = 0; u < NU; u++) begin
      fd_cnt[u] = 0; busy_cnt[u] = 0; last_seen[u] = -1;
    end
  endtask

  task automatic do_start(input logic c, input logic [2:0] li);
    cont = c; last_idx = li; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((obs[0][1] | obs[1][1] | obs[2][1] | obs[3][1]) && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s_timeout got=busy expected=idle within 400 cycles", name);
    end
  endtask

  initial begin
    logic [6:0] pat;
    int n;
    clear_cnt();
    repeat (2) tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_state", int'(obs[0]), 0);

    // One-shot full frame.
    clear_cnt();
    do_start(1'b0, 3'd7);
    @(negedge clk);
    #1;
    check("first_slot", int'(obs[0]), 6'b000110);
    wait_idle("oneshot");
    check("oneshot_fd_div4", fd_cnt[0], 1);
    check("oneshot_busy_div4", busy_cnt[0], 32 + 7 * BL);
    check("oneshot_busy_div3", busy_cnt[1], 24 + 7 * BL);
    check("oneshot_fd_div1", fd_cnt[3], 1);

    // Continuous wrap, stop in the final cycle of index 1 on the DIV=2 unit.
    clear_cnt();
    do_start(1'b1, 3'd2);
    repeat (8) tick();
    n = 0;
    while (!(obs[2][2] && obs[2][5:3] == 3'd1) && n < 100) begin
      tick();
      n++;
    end
    check("wait_idx1_bound", int'(n < 100), 1);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle("cont_stop");
    check("cont_last_idx", last_seen[2], 2);
    check("cont_fd_div2", fd_cnt[2], 2);
    check("cont_busy_div2", busy_cnt[2], 12 + 5 * BL);

    // DIV=1, last_idx=0, start and stop in the same IDLE cycle.
    clear_cnt();
    cont = 1'b1; last_idx = 3'd0; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    repeat (6) tick();
    check("startstop_busy", int'(obs[3][1]), 1);
    check("div1_fd_count", fd_cnt[3], 6 / (1 + BL));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle("div1_stop");

    // Start and parameter changes while busy are ignored.
    clear_cnt();
    do_start(1'b0, 3'd3);
    repeat (2) tick();
    last_idx = 3'd7; cont = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("ignored");
    check("ignored_busy_div3", busy_cnt[1], 12 + 3 * BL);
    check("ignored_fd_div3", fd_cnt[1], 1);
    check("ignored_last_idx", last_seen[1], 3);

    // Stop in IDLE does nothing.
    clear_cnt();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (3) tick();
    check("idle_stop_busy", busy_cnt[0] + busy_cnt[3], 0);

    // Valid pattern for DIV=3, last_idx=1, one-shot.
    clear_cnt();
    do_start(1'b0, 3'd1);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      #1;
      pat[6 - c] = obs[1][2];
    end
    check("valid_pattern", int'(pat), (BL == 1) ? 7'b1110111 : 7'b1111110);
    check("pattern_fd", fd_cnt[1], 1);
    wait_idle("pattern");

    // Reset mid-frame.
    clear_cnt();
    do_start(1'b1, 3'd7);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset_div4", int'(obs[0]), 0);
    check("midreset_div2", int'(obs[2]), 0);
    check("midreset_fd_div4", fd_cnt[0], 0);
    repeat (3) tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_select_gen.md
# scan_select_gen

Sequencer that drives the 3-bit select (x, y, z) of the downstream 3-to-8 decoder, stepping through output indices 0..last_idx at a programmable slot rate. It provides start/stop control, one-shot and continuous modes, a select-valid qualifier and an end-of-frame pulse. It is the upstream stage for digit/row scanning, where each decoder output enables one scanned element.

## Interface
- DIV, 100, clock cycles per slot (one index held for DIV cycles); legal range 1..65535
- CNT_W, $clog2(DIV) (min 1), prescaler counter width; derived, not overridden
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE
- stop  in  1  one-cycle request to end scanning after the current slot
- cont  in  1  1 = continuous (wrap after last_idx), 0 = one-shot; sampled with start
- last_idx  in  3  highest index scanned; sampled with start
- x  out  1  select MSB (index bit 2), registered
- y  out  1  select bit 1, registered
- z  out  1  select LSB (index bit 0), registered
- sel_valid  out  1  1 while {x,y,z} is a live slot; decoder output is meaningful only when 1
- busy  out  1  1 in any state other than IDLE
- frame_done  out  1  one-cycle pulse in the final cycle of the slot for last_idx

## Operation
- States: IDLE, RUN, BLANK (BLANK exists only with SCAN_BLANK_EN).
- Reset: state IDLE; x=y=z=0, sel_valid=0, busy=0, frame_done=0; prescaler=0; stop_pend=0; captured last_idx/cont=0. Reset asserted mid-frame aborts on the next edge, with no frame_done.
- IDLE: outputs as at reset. start=1 → RUN next cycle with index 0, prescaler=0, and last_idx/cont captured. stop in IDLE is ignored. start and stop in the same IDLE cycle: start is accepted, stop is dropped.
- RUN: the index is held; the prescaler counts 0..DIV-1. A slot ends in the cycle where prescaler==DIV-1.
- Slot end, index==captured last_idx: frame_done=1 that cycle.
  - cont=0: go to IDLE.
  - cont=1 and no stop pending: index wraps to 0.
- Slot end, index<last_idx: index+1 (3-bit, no overflow possible).
- stop in RUN/BLANK sets stop_pend. At the next slot end, go to IDLE instead of advancing. frame_done still fires if that slot was last_idx. stop_pend clears on entering IDLE.
- start while busy is ignored. last_idx and cont changes while busy have no effect.
- last_idx=0: a single index 0 is scanned. In continuous mode frame_done pulses every DIV cycles (every DIV+1 with blanking).

## Timing
- start at edge N → sel_valid=1, {x,y,z}=000 after edge N+1.
- Each index is held exactly DIV cycles; frame length is (last_idx+1)·DIV cycles without blanking.
- frame_done coincides with the last cycle of the final slot, and is never asserted for two consecutive cycles unless DIV=1 and last_idx=0.
- IDLE re-entry: busy=0 on the edge after the final slot cycle. A start in that same IDLE cycle is accepted.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SCAN_BLANK_EN defined: after every slot end that advances or wraps, insert 1 BLANK cycle. In BLANK, sel_valid=0 and {x,y,z} already shows the next index. RUN resumes on the following cycle with prescaler=0. No BLANK is inserted before entering IDLE. A stop seen in BLANK takes effect at the end of the next slot.
- SCAN_BLANK_EN undefined: the BLANK state and its logic are absent, and slots are back-to-back with sel_valid continuously 1.

## Structure
- Package scan_pkg holds:
  - SEL_W=3 and NUM_OUT=8
  - the state enum {IDLE, RUN, BLANK}
  - the select struct/typedef (3-bit index)
- Sub-module scan_prescaler: a 0..DIV-1 counter with clear input and terminal-count output `tc`, instantiated once. The FSM and index register stay in scan_select_gen.

## Test plan
- Reset mid-frame: DIV=4, last_idx=7, cont=1, assert rst at cycle 10 → next edge gives all outputs 0, busy=0, and no frame_done.
- One-shot: DIV=4, last_idx=7, cont=0, start → index 0..7 each held 4 cycles, frame_done once at cycle 32, busy=0 from cycle 33.
- Continuous wrap: DIV=2, last_idx=2, cont=1 → sequence 0,0,1,1,2,2,0,… with frame_done every 6 cycles. Stop during index 1 → index 2 completes, then IDLE.
- Edge parameters: DIV=1, last_idx=0, cont=1 → frame_done high every cycle and index constant 0. Start+stop in the same IDLE cycle → scan starts.
- Ignored requests: start while busy and last_idx changed mid-frame → sequence unchanged. Stop in IDLE → stays IDLE.
- SCAN_BLANK_EN, DIV=3, last_idx=1, cont=0 → valid pattern 1,1,1,0,1,1,1 with index 0 then 1, and frame_done in cycle 7.
